// File: rtl/branch_resolve_mem.sv
// branch_resolve_mem: EX/MEM pipeline register with beq/bne resolution and wrong-path squash
// Optional feature macro: BRANCH_STATS_EN adds the branch_count and taken_count ports.
// Ports:
//   clk, reset (async, active-low), stall (hold everything)
//   ex_*            EX-stage results and control bits to latch
//   pc_branch       latched branch target; pc_source/flush = branch taken
//   mem_*           latched instruction fields for the MEM stage
//   branch_count, taken_count  16-bit wrapping statistics (BRANCH_STATS_EN only)
module branch_resolve_mem #(
  parameter int WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHADOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic                  ex_bne,
  input  logic                  ex_zero,
  input  logic [WIDTH-1:0]      ex_target,
  input  logic [WIDTH-1:0]      ex_alu_result,
  input  logic [WIDTH-1:0]      ex_write_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  output logic [WIDTH-1:0]      pc_branch,
  output logic                  pc_source,
  output logic                  flush,
  output logic                  mem_valid,
  output logic [WIDTH-1:0]      mem_alu_result,
  output logic [WIDTH-1:0]      mem_write_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           branch_count,
  output logic [15:0]           taken_count
`endif
);
  typedef enum logic {ARMED, SQUASH} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic       mem_branch, mem_bne, mem_zero, taken, keep;
  assign taken     = mem_valid & mem_branch & (mem_zero ^ mem_bne);
  assign pc_source = taken;
  assign flush     = taken;
  // Bubbles and wrong-path captures lose validity and every side-effecting control bit.
  assign keep      = ex_valid & (state == ARMED);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARMED;
      cnt            <= '0;
      mem_valid      <= 1'b0;
      mem_branch     <= 1'b0;
      mem_bne        <= 1'b0;
      mem_zero       <= 1'b0;
      pc_branch      <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= keep;
      mem_branch     <= keep & ex_branch;
      mem_bne        <= ex_bne;
      mem_zero       <= ex_zero;
      pc_branch      <= ex_target;
      mem_alu_result <= ex_alu_result;
      mem_write_data <= ex_write_data;
      mem_rd         <= ex_rd;
      mem_reg_write  <= keep & ex_reg_write;
      mem_mem_read   <= keep & ex_mem_read;
      mem_mem_write  <= keep & ex_mem_write;
      mem_mem_to_reg <= keep & ex_mem_to_reg;
      // The capture on the redirect edge itself is normal; the next SHADOW captures are squashed.
      state <= (state == ARMED) ? (taken ? SQUASH : ARMED) : (cnt == 3'd1 ? ARMED : SQUASH);
      cnt   <= (state == ARMED) ? (taken ? 3'(SHADOW) : cnt) : cnt - 3'd1;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall) begin
      branch_count <= branch_count + 16'(mem_valid & mem_branch);
      taken_count  <= taken_count + 16'(taken);
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_mem.sv
// tb_branch_resolve_mem: directed checks of capture, resolution, squash, stall and reset
module tb_branch_resolve_mem;
  localparam int SH = 2;
  logic        clk = 1'b0, reset = 1'b0, stall = 1'b0;
  logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_bne = 1'b0, ex_zero = 1'b0;
  logic [31:0] ex_target = '0, ex_alu_result = '0, ex_write_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_mem_to_reg = 1'b0;
  logic [31:0] pc_branch, mem_alu_result, mem_write_data;
  logic        pc_source, flush, mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  int          errors = 0, checks = 0;
`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count, taken_count;
`endif
  branch_resolve_mem #(.WIDTH(32), .REG_ADDR_W(5), .SHADOW(SH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_zero(ex_zero),
    .ex_target(ex_target), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .pc_branch(pc_branch), .pc_source(pc_source), .flush(flush), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count), .taken_count(taken_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic br, input logic bne, input logic z,
                       input logic [31:0] tgt, input logic [31:0] alu, input logic rw);
    ex_valid = v; ex_branch = br; ex_bne = bne; ex_zero = z;
    ex_target = tgt; ex_alu_result = alu; ex_reg_write = rw;
  endtask
  initial begin
    #2;
    check("rst_pc_source", 32'(pc_source), 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_pc_branch", pc_branch, 0);
    reset = 1'b1;
    // plain ALU instruction
    drive(1, 0, 0, 0, 32'h0, 32'h10, 1); ex_rd = 5'd5; ex_write_data = 32'hAB;
    step();
    check("alu_result", mem_alu_result, 32'h10);
    check("alu_rd", 32'(mem_rd), 5);
    check("alu_reg_write", 32'(mem_reg_write), 1);
    check("alu_write_data", mem_write_data, 32'hAB);
    check("alu_pc_source", 32'(pc_source), 0);
    // taken beq
    drive(1, 1, 0, 1, 32'h40, 32'h0, 0);
    step();
    check("beq_pc_source", 32'(pc_source), 1);
    check("beq_flush", 32'(flush), 1);
    check("beq_pc_branch", pc_branch, 32'h40);
    // redirect edge, then SH squashed captures
    drive(1, 0, 0, 0, 32'h0, 32'h20, 1);
    step();
    check("redir_pc_source", 32'(pc_source), 0);
    for (int i = 0; i < SH; i++) begin
      step();
      check("squash_valid", 32'(mem_valid), 0);
      check("squash_reg_write", 32'(mem_reg_write), 0);
      check("squash_data", mem_alu_result, 32'h20);
    end
    // bne with zero=1: not taken; also proves the shadow ended after SH captures
    drive(1, 1, 1, 1, 32'h60, 32'h0, 0);
    step();
    check("bne_nt_valid", 32'(mem_valid), 1);
    check("bne_nt_pc_source", 32'(pc_source), 0);
    // bne with zero=0: taken
    drive(1, 1, 1, 0, 32'h80, 32'h33, 0);
    step();
    check("bne_t_pc_source", 32'(pc_source), 1);
    check("bne_t_pc_branch", pc_branch, 32'h80);
    // stall while taken: redirect held, registers frozen
    stall = 1'b1;
    drive(1, 0, 0, 0, 32'h0, 32'h99, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc_source", 32'(pc_source), 1);
      check("stall_hold", mem_alu_result, 32'h33);
    end
    stall = 1'b0;
    step();
    check("release_pc_source", 32'(pc_source), 0);
    // taken beq arriving during the shadow must be squashed and never resolve
    drive(1, 1, 0, 1, 32'hC0, 32'h0, 0);
    for (int i = 0; i < SH; i++) begin
      step();
      check("shadow_branch_valid", 32'(mem_valid), 0);
      check("shadow_branch_pc_source", 32'(pc_source), 0);
    end
    step();
    check("post_shadow_pc_source", 32'(pc_source), 1);
    check("post_shadow_pc_branch", pc_branch, 32'hC0);
    // bubble on the redirect edge
    drive(0, 1, 0, 1, 32'hD0, 32'h0, 1);
    step();
    check("bubble_valid", 32'(mem_valid), 0);
    check("bubble_reg_write", 32'(mem_reg_write), 0);
    check("bubble_pc_source", 32'(pc_source), 0);
    // async reset mid-squash
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(mem_valid), 0);
    check("async_rst_pc_branch", pc_branch, 0);
    check("async_rst_alu", mem_alu_result, 0);
    reset = 1'b1;
    drive(1, 1, 0, 1, 32'h44, 32'h0, 0);
    step();
    check("after_rst_valid", 32'(mem_valid), 1);
    check("after_rst_pc_source", 32'(pc_source), 1);
`ifdef BRANCH_STATS_EN
    reset = 1'b0;
    #1;
    check("stats_rst_branch", 32'(branch_count), 0);
    check("stats_rst_taken", 32'(taken_count), 0);
    reset = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, 0, (b < 3) ? 1'b1 : 1'b0, 32'h100, 32'h0, 0);
      step();
      drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < SH + 2; i++) step();
    end
    check("stats_branch_count", 32'(branch_count), 4);
    check("stats_taken_count", 32'(taken_count), 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
